// File: rtl/uart_prog_loader.sv
// UART 8N1 receiver that streams received bytes into a 16 x 8 program memory.
// Latency: rx_valid pulses one cycle after the stop-bit sample; memory write lands on that same edge.
// Backpressure: none; ena=0 freezes all state, forces rx_valid low, and leaves rd_data live.
//
// Ports:
//   clk, rst_n    - system clock, asynchronous active-low reset
//   ena           - global enable (hold all state when 0)
//   rx            - asynchronous serial input, idle high, 8N1 LSB first
//   load_en       - when 1, valid bytes are written at wr_ptr
//   rd_addr       - program memory read address
//   rd_data       - combinational read of mem[rd_addr]
//   rx_valid      - one-cycle pulse per validly framed byte
//   rx_byte       - last validly framed byte
//   frame_err     - sticky, set when a stop bit samples 0
//   wr_ptr        - next write address
//   prog_full     - all 16 locations written since load_en rose
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx,
    input  logic       load_en,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic [3:0] wr_ptr,
    output logic       prog_full
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          rx_meta, rx_s;
    logic          rx_valid_q;
    logic          load_en_q;
    logic [7:0]    mem [16];

    logic stop_hit, good_stop, bad_stop, load_rise, do_write;

    // Stop bit is evaluated in the last count of STOP, i.e. the centre of the stop bit.
    assign stop_hit  = (state == STOP) && (cnt == CNT_LAST);
    assign good_stop = stop_hit & rx_s;
    assign bad_stop  = stop_hit & ~rx_s;
    assign load_rise = load_en & ~load_en_q;
    // The write decision uses load_en as seen in the stop-sample cycle only.
    assign do_write  = good_stop & load_en & ~prog_full;

    assign rd_data  = mem[rd_addr];
    assign rx_valid = rx_valid_q & ena;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    // A high line at mid start bit is a glitch, not a frame.
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {rx_s, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (ena) begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            rx_byte    <= 8'h00;
            frame_err  <= 1'b0;
            wr_ptr     <= 4'd0;
            prog_full  <= 1'b0;
            load_en_q  <= 1'b0;
        end else if (!ena) begin
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= good_stop;
            load_en_q  <= load_en;
            if (good_stop) rx_byte <= shift;
            if (load_rise) frame_err <= 1'b0;
            if (bad_stop)  frame_err <= 1'b1;
            if (!load_en || load_rise) begin
                wr_ptr    <= 4'd0;
                prog_full <= 1'b0;
            end
            if (do_write) begin
                wr_ptr <= wr_ptr + 4'd1;
                if (wr_ptr == 4'd15) prog_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (ena && do_write) begin
            mem[wr_ptr] <= shift;
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;
    localparam int CPB   = 16;
    localparam int PAUSE = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       rx = 1'b1;
    logic       load_en = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic [3:0] wr_ptr;
    logic       prog_full;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    uart_prog_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .rx        (rx),
        .load_en   (load_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err),
        .wr_ptr    (wr_ptr),
        .prog_full (prog_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string name);
        rd_addr = a;
        #1;
        check(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    // Drives one frame starting at a negedge. Frame bit 0 is start, 1..8 data, 9 stop.
    // abort_bit >= 0 returns before driving that frame bit; pause_bit >= 0 drops ena
    // for PAUSE cycles in the middle of that frame bit.
    task automatic tx_frame(input logic [7:0] b, input logic stop_bit,
                            input int abort_bit, input int pause_bit);
        logic [9:0] frame;
        int k, extra;
        frame = {stop_bit, b, 1'b0};
        extra = (pause_bit >= 0) ? PAUSE : 0;
        k = cyc + 1;
        // rx_s low from cycle k+1 (t0); pulse in cycle t0 + CPB/2 + 9*CPB + 1.
        if (stop_bit && abort_bit < 0)
            sb.push_back('{b, k + 2 + CPB / 2 + 9 * CPB + extra});
        for (int i = 0; i < 10; i++) begin
            if (i == abort_bit) return;
            rx = frame[i];
            if (i == pause_bit) begin
                repeat (CPB / 2) @(negedge clk);
                ena = 1'b0;
                repeat (PAUSE) @(negedge clk);
                ena = 1'b1;
                repeat (CPB / 2) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest expected byte and cycle.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_rx_valid: got byte %0h at cycle %0d, required no pulse",
                         rx_byte, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rx_byte", {24'd0, rx_byte}, {24'd0, e.b});
                check("rx_valid_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        // Reset state, checked while reset is held.
        #2;
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_byte", rx_byte, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_prog_full", prog_full, 0);
        peek(4'd9, 8'h00, "rst_rd_data");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        load_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte with load enabled.
        tx_frame(8'hA5, 1'b1, -1, -1);
        peek(4'd0, 8'hA5, "a5_mem0");
        check("a5_wr_ptr", wr_ptr, 1);
        check("a5_frame_err", frame_err, 0);

        // Restart loading, fill all 16 locations, then one more byte.
        load_en = 1'b0;
        @(negedge clk);
        check("load_off_wr_ptr", wr_ptr, 0);
        load_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            v = 8'h10 + 8'(i);
            tx_frame(v, 1'b1, -1, -1);
        end
        check("fill_prog_full", prog_full, 1);
        check("fill_wr_ptr", wr_ptr, 0);
        peek(4'd15, 8'h1F, "fill_mem15");
        peek(4'd0, 8'h10, "fill_mem0");
        tx_frame(8'hFF, 1'b1, -1, -1);
        peek(4'd0, 8'h10, "full_mem0_kept");
        check("full_wr_ptr", wr_ptr, 0);
        check("full_prog_full", prog_full, 1);

        // Framing error, then clear by load_en rising edge.
        tx_frame(8'h3C, 1'b0, -1, -1);
        check("ferr_set", frame_err, 1);
        check("ferr_wr_ptr", wr_ptr, 0);
        check("ferr_rx_byte", rx_byte, 8'hFF);
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        check("ferr_sticky", frame_err, 1);
        load_en = 1'b1;
        @(negedge clk);
        check("ferr_cleared", frame_err, 0);
        check("reload_prog_full", prog_full, 0);

        // Short glitch is rejected, following byte still received.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_frame_err", frame_err, 0);
        check("glitch_wr_ptr", wr_ptr, 0);
        tx_frame(8'h5A, 1'b1, -1, -1);
        peek(4'd0, 8'h5A, "5a_mem0");
        check("5a_wr_ptr", wr_ptr, 1);

        // ena dropped for PAUSE cycles during data bit 3 (frame bit 4).
        tx_frame(8'h96, 1'b1, -1, 4);
        peek(4'd1, 8'h96, "96_mem1");
        check("96_wr_ptr", wr_ptr, 2);

        // Reset in the middle of the third byte.
        tx_frame(8'hC3, 1'b1, 5, -1);
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        check("midrst_wr_ptr", wr_ptr, 0);
        peek(4'd0, 8'h00, "midrst_mem0");
        peek(4'd1, 8'h00, "midrst_mem1");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tx_frame(8'h77, 1'b1, -1, -1);
        peek(4'd0, 8'h77, "post_rst_mem0");
        check("post_rst_wr_ptr", wr_ptr, 1);

        // Load disabled: byte seen on rx_byte only, memory retained.
        load_en = 1'b0;
        @(negedge clk);
        tx_frame(8'h33, 1'b1, -1, -1);
        check("noload_wr_ptr", wr_ptr, 0);
        check("noload_prog_full", prog_full, 0);
        peek(4'd0, 8'h77, "noload_mem0_kept");

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
